// File: rtl/lsu_req_ctrl_pkg.sv
// Shared encodings for the LSU request sequencer: FSM states, access sizes,
// load funct3 codes and the natural-alignment check.
package lsu_req_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] wlen);
    logic ok;
    ok = 1'b1;
    case (wlen)
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      SZ_D:    ok = (addr_lo == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_req_ctrl_if.sv
// Dcache request/response port: valid/ready request channel plus a response strobe.
interface lsu_req_ctrl_if;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i;
  logic        dc_wen_o;
  logic [63:0] dc_addr_o;
  logic [63:0] dc_wdata_o;
  logic [1:0]  dc_wlen_o;
  logic        dc_resp_valid_i;
  logic [63:0] dc_rdata_i;

  modport master (
    output dc_req_valid_o, dc_wen_o, dc_addr_o, dc_wdata_o, dc_wlen_o,
    input  dc_req_ready_i, dc_resp_valid_i, dc_rdata_i
  );

  modport slave (
    input  dc_req_valid_o, dc_wen_o, dc_addr_o, dc_wdata_o, dc_wlen_o,
    output dc_req_ready_i, dc_resp_valid_i, dc_rdata_i
  );
endinterface

// File: rtl/lsu_req_ctrl_load_ext.sv
// Load result extension: selects sign/zero extension of right-justified dcache data by funct3.
module lsu_load_ext
  import lsu_req_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{56{rdata_i[7]}},  rdata_i[7:0]};
      FUNCT3_LH:  data_o = {{48{rdata_i[15]}}, rdata_i[15:0]};
      FUNCT3_LW:  data_o = {{32{rdata_i[31]}}, rdata_i[31:0]};
      FUNCT3_LD:  data_o = rdata_i;
      FUNCT3_LBU: data_o = {56'd0, rdata_i[7:0]};
      FUNCT3_LHU: data_o = {48'd0, rdata_i[15:0]};
      FUNCT3_LWU: data_o = {32'd0, rdata_i[31:0]};
      default:    data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Single-outstanding load/store sequencer between ID and the dcache port, with
// misalignment rejection, flush draining and a response timeout.
module lsu_req_ctrl
  import lsu_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_req_valid_i,
  input  logic          id_wen_i,
  input  logic [63:0]   id_addr_i,
  input  logic [63:0]   id_wdata_i,
  input  logic [1:0]    id_wlen_i,
  input  logic [2:0]    id_funct3_i,
  input  logic [4:0]    id_rd_addr_i,
  input  logic          flush_i,
  lsu_req_ctrl_if.master dc,
  output logic          stall_o,
  output logic          ld_valid_o,
  output logic [63:0]   ld_data_o,
  output logic [4:0]    ld_rd_addr_o,
  output logic          misalign_o,
  output logic          timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wen_q, req_vld_q, ld_pend_q, misalign_q, timeout_q;
  logic [63:0] addr_q, wdata_q, ld_data_q, ext_data;
  logic [1:0]  wlen_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q, ld_rd_q;
  logic        aligned, cnt_exp;

  assign aligned = is_aligned(id_addr_i[2:0], id_wlen_i);
  assign cnt_exp = (cnt_q == CNT_LAST);
  // Counter wraps at expiry so DRAIN can time a second full window.
  assign cnt_d   = cnt_exp ? '0 : cnt_q + 1'b1;

  lsu_load_ext u_ext (
    .funct3_i (funct3_q),
    .rdata_i  (dc.dc_rdata_i),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wlen_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      req_vld_q  <= 1'b0;
      ld_pend_q  <= 1'b0;
      ld_data_q  <= '0;
      ld_rd_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      ld_pend_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (id_req_valid_i && !flush_i) begin
            if (aligned) begin
              wen_q     <= id_wen_i;
              addr_q    <= id_addr_i;
              wdata_q   <= id_wdata_i;
              wlen_q    <= id_wlen_i;
              funct3_q  <= id_funct3_i;
              rd_q      <= id_rd_addr_i;
              req_vld_q <= 1'b1;
              state_q   <= ST_REQ;
            end else begin
              misalign_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // An accepted request must still be drained even if flushed this cycle.
          if (dc.dc_req_ready_i) begin
            req_vld_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= flush_i ? ST_DRAIN : ST_RESP;
          end else if (flush_i) begin
            req_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (dc.dc_resp_valid_i) begin
            state_q <= ST_DONE;
            if (!wen_q) begin
              ld_data_q <= ext_data;
              ld_rd_q   <= rd_q;
              ld_pend_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
              state_q <= ST_DRAIN;
            end else if (cnt_exp) begin
              timeout_q <= 1'b1;
              state_q   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dc.dc_resp_valid_i) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_exp) state_q <= ST_IDLE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o = (state_q == ST_IDLE && id_req_valid_i && aligned && !flush_i)
                 || state_q == ST_REQ || state_q == ST_RESP || state_q == ST_DRAIN;

  assign dc.dc_req_valid_o = req_vld_q;
  assign dc.dc_wen_o       = wen_q;
  assign dc.dc_addr_o      = addr_q;
  assign dc.dc_wdata_o     = wdata_q;
  assign dc.dc_wlen_o      = wlen_q;

  assign ld_valid_o   = ld_pend_q & ~flush_i;
  assign ld_data_o    = ld_data_q;
  assign ld_rd_addr_o = ld_rd_q;
  assign misalign_o   = misalign_q;
  assign timeout_o    = timeout_q;

endmodule
